// File: rtl/beehive_ctrl_noc_msg.sv
// Shared NOC message definitions for the ctrl/data NOC header converters:
// flit widths, header layouts and the extra-header flit count helper.
package beehive_ctrl_noc_msg;

  localparam int NOC_DATA_WIDTH   = 512;
  localparam int CTRL_NOC1_DATA_W = 64;
  localparam int BASE_FLIT_W      = 2 * CTRL_NOC1_DATA_W;
  localparam int MSG_LEN_W        = 8;

  typedef struct packed {
    logic [7:0]           dst_x;
    logic [7:0]           dst_y;
    logic [3:0]           dst_fbits;
    logic [MSG_LEN_W-1:0] msg_len;
    logic [7:0]           msg_type;
    logic [7:0]           src_x;
    logic [7:0]           src_y;
    logic [3:0]           src_fbits;
    logic [7:0]           rsvd;
  } routing_hdr_flit;

  // Wide header flit: routing word, misc word, then the extra-header region.
  typedef struct packed {
    routing_hdr_flit                          core;
    logic [7:0]                               metadata_flits;
    logic [CTRL_NOC1_DATA_W-9:0]              misc;
    logic [NOC_DATA_WIDTH-BASE_FLIT_W-1:0]    body;
  } beehive_noc_hdr_flit;

  // Both converter ends call this so they agree on the ctrl-flit count.
  function automatic int extra_hdr_flits(input int extra_w);
    return (extra_w + CTRL_NOC1_DATA_W - 1) / CTRL_NOC1_DATA_W;
  endfunction

endpackage

// File: rtl/extra_hdr_noc_data_to_ctrl.sv
// Serializes one wide header flit with an extra-header field into ctrl NOC
// flits: routing header (length patched), misc header, extra chunks MSB-first.
module extra_hdr_noc_data_to_ctrl
  import beehive_ctrl_noc_msg::*;
#(
  parameter int EXTRA_W = 96
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        src_noc_dtc_val,
  input  logic [NOC_DATA_WIDTH-1:0]   src_noc_dtc_data,
  output logic                        noc_dtc_src_rdy,
  output logic                        noc_dtc_dst_val,
  output logic [CTRL_NOC1_DATA_W-1:0] noc_dtc_dst_data,
  input  logic                        dst_noc_dtc_rdy,
  output logic [1:0]                  dbg_state_o
);

  localparam int EXTRA_FLITS = extra_hdr_flits(EXTRA_W);
  localparam int SAVE_W      = EXTRA_FLITS * CTRL_NOC1_DATA_W;
  localparam int IDX_W       = (EXTRA_FLITS > 1) ? $clog2(EXTRA_FLITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(EXTRA_FLITS - 1);

  localparam logic [1:0] ST_READY     = 2'd0;
  localparam logic [1:0] ST_HDR_1     = 2'd1;
  localparam logic [1:0] ST_HDR_2     = 2'd2;
  localparam logic [1:0] ST_REM_FLITS = 2'd3;

  if (EXTRA_W <= 0 || EXTRA_W > NOC_DATA_WIDTH - BASE_FLIT_W) begin : g_bad_extra_w
    $error("EXTRA_W must be in 1..NOC_DATA_WIDTH-BASE_FLIT_W");
  end

  // Handshake rules: a side transfers on a clock edge where val & rdy.
  // dst_val depends only on state; src_rdy is high in READY and, on the last
  // extra beat, follows dst_rdy combinationally so a new flit can chain in.
  logic [1:0]                state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [NOC_DATA_WIDTH-1:0] flit_q, flit_d;

  beehive_noc_hdr_flit         hdr_view;
  routing_hdr_flit             hdr1;
  logic [EXTRA_W-1:0]          extra;
  logic [SAVE_W-1:0]           padded;
  logic [CTRL_NOC1_DATA_W-1:0] chunks [EXTRA_FLITS];
  logic                        last_beat;
  logic                        capture;
  logic                        unused_flit;

  assign hdr_view = flit_q;
  assign extra    = hdr_view.body[NOC_DATA_WIDTH-BASE_FLIT_W-1 -: EXTRA_W];
  assign padded   = SAVE_W'(extra) << (SAVE_W - EXTRA_W);
  // Body bits below the extra field are carried in the register but never sent.
  assign unused_flit = ^hdr_view.body;

  for (genvar g = 0; g < EXTRA_FLITS; g++) begin : g_chunk
    assign chunks[g] = padded[g*CTRL_NOC1_DATA_W +: CTRL_NOC1_DATA_W];
  end

  always_comb begin
    hdr1         = hdr_view.core;
    hdr1.msg_len = MSG_LEN_W'(1 + EXTRA_FLITS);
  end

  assign last_beat       = (state_q == ST_REM_FLITS) && (idx_q == '0);
  assign noc_dtc_dst_val = (state_q != ST_READY);
  assign noc_dtc_src_rdy = rst_n & ((state_q == ST_READY) | (last_beat & dst_noc_dtc_rdy));
  assign capture         = src_noc_dtc_val & noc_dtc_src_rdy;
  assign dbg_state_o     = state_q;

  always_comb begin
    noc_dtc_dst_data = '0;
    case (state_q)
      ST_HDR_1:     noc_dtc_dst_data = hdr1;
      ST_HDR_2:     noc_dtc_dst_data = {hdr_view.metadata_flits, hdr_view.misc};
      ST_REM_FLITS: noc_dtc_dst_data = chunks[idx_q];
      default:      noc_dtc_dst_data = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    flit_d  = flit_q;
    case (state_q)
      ST_HDR_1: if (dst_noc_dtc_rdy) state_d = ST_HDR_2;
      ST_HDR_2: if (dst_noc_dtc_rdy) state_d = ST_REM_FLITS;
      ST_REM_FLITS: begin
        if (dst_noc_dtc_rdy) begin
          if (idx_q != '0) idx_d = idx_q - IDX_W'(1);
          else             state_d = ST_READY;
        end
      end
      default: state_d = ST_READY;
    endcase
    // Capture wins over the READY fallback so back-to-back messages have no bubble.
    if (capture) begin
      flit_d  = src_noc_dtc_data;
      idx_d   = IDX_LAST;
      state_d = ST_HDR_1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_READY;
      idx_q   <= '0;
      flit_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      flit_q  <= flit_d;
    end
  end

endmodule

// File: tb/tb_extra_hdr_noc_data_to_ctrl.sv
// Directed bench for the data-to-ctrl extra-header serializer (EXTRA_W=96 and
// EXTRA_W=64 instances) with a ctrl-side scoreboard.
module tb_extra_hdr_noc_data_to_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         src_val, src_rdy, dst_val, dst_rdy;
  logic [511:0] src_data;
  logic [63:0]  dst_data;
  logic [1:0]   state;
  logic         src_val_b, src_rdy_b, dst_val_b, dst_rdy_b;
  logic [511:0] src_data_b;
  logic [63:0]  dst_data_b;
  logic [1:0]   state_b;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic        stall_seen = 1'b0;
  logic [63:0] stall_data = '0;

  always #5 clk = ~clk;

  extra_hdr_noc_data_to_ctrl #(.EXTRA_W(96)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .src_noc_dtc_val(src_val), .src_noc_dtc_data(src_data), .noc_dtc_src_rdy(src_rdy),
    .noc_dtc_dst_val(dst_val), .noc_dtc_dst_data(dst_data), .dst_noc_dtc_rdy(dst_rdy),
    .dbg_state_o(state)
  );

  extra_hdr_noc_data_to_ctrl #(.EXTRA_W(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n),
    .src_noc_dtc_val(src_val_b), .src_noc_dtc_data(src_data_b), .noc_dtc_src_rdy(src_rdy_b),
    .noc_dtc_dst_val(dst_val_b), .noc_dtc_dst_data(dst_data_b), .dst_noc_dtc_rdy(dst_rdy_b),
    .dbg_state_o(state_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [511:0] mk_flit(input logic [63:0] h1, input logic [63:0] h2,
                                           input logic [95:0] ext);
    return {h1, h2, ext, {288{1'b1}}};
  endfunction

  // Expected ctrl beats: msg_len (bits 43:36) forced to 3, extra MSB-first, zero pad.
  task automatic push_msg(input logic [63:0] h1, input logic [63:0] h2, input logic [95:0] ext);
    exp_q.push_back((h1 & ~(64'hFF << 36)) | (64'h3 << 36));
    exp_q.push_back(h2);
    exp_q.push_back(ext[95:32]);
    exp_q.push_back({ext[31:0], 32'h0});
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (dst_val && n < 40) begin
      sample();
      n++;
    end
    check(tag, {63'd0, dst_val}, 64'd0);
  endtask

  // Ctrl-side scoreboard: every accepted beat must match the next expected beat,
  // and a stalled beat must stay valid with unchanged data.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_seen = 1'b0;
    end else begin
      if (stall_seen) begin
        check("stall_val_held", {63'd0, dst_val}, 64'd1);
        check("stall_data_held", dst_data, stall_data);
      end
      if (dst_val && dst_rdy) begin
        check("beat_expected", {63'd0, exp_q.size() > 0}, 64'd1);
        if (exp_q.size() > 0) check("beat_data", dst_data, exp_q.pop_front());
      end
      stall_seen = dst_val && !dst_rdy;
      stall_data = dst_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int remaining;
    rst_n = 1'b0; src_val = 1'b0; src_data = '0; dst_rdy = 1'b1;
    src_val_b = 1'b0; src_data_b = '0; dst_rdy_b = 1'b1;

    // Reset state
    repeat (2) tick();
    sample();
    check("rst_dst_val", {63'd0, dst_val}, 64'd0);
    check("rst_src_rdy", {63'd0, src_rdy}, 64'd0);
    check("rst_dst_data", dst_data, 64'd0);
    check("rst_state", {62'd0, state}, 64'd0);
    tick(); rst_n = 1'b1;
    sample();
    check("idle_src_rdy", {63'd0, src_rdy}, 64'd1);
    check("idle_dst_val", {63'd0, dst_val}, 64'd0);

    // Single message with hand-computed beats
    exp_q.push_back(64'h1111_1031_1111_1111);
    exp_q.push_back(64'h2222_2222_2222_2222);
    exp_q.push_back(64'hAAAA_BBBB_CCCC_DDDD);
    exp_q.push_back(64'hEEEE_FFFF_0000_0000);
    tick(); src_val = 1'b1;
    src_data = mk_flit(64'h1111_1001_1111_1111, 64'h2222_2222_2222_2222,
                       96'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF);
    tick(); src_val = 1'b0;
    sample();
    check("s1_latency_val", {63'd0, dst_val}, 64'd1);
    check("s1_state_hdr1", {62'd0, state}, 64'd1);
    check("s1_hdr1_src_rdy", {63'd0, src_rdy}, 64'd0);
    sample();
    check("s1_state_hdr2", {62'd0, state}, 64'd2);
    check("s1_hdr2_src_rdy", {63'd0, src_rdy}, 64'd0);
    sample();
    check("s1_rem_src_rdy", {63'd0, src_rdy}, 64'd0);
    sample();
    check("s1_last_src_rdy", {63'd0, src_rdy}, 64'd1);
    sample();
    check("s1_done_val", {63'd0, dst_val}, 64'd0);
    check("s1_done_state", {62'd0, state}, 64'd0);
    check("s1_queue_empty", 64'(exp_q.size()), 64'd0);

    // Backpressure: dst_rdy pattern 1,0,0,1
    push_msg(64'h0102_0003_0405_0607, 64'h8877_6655_4433_2211, 96'h0123_4567_89AB_CDEF_FEDC_BA98);
    tick(); src_val = 1'b1;
    src_data = mk_flit(64'h0102_0003_0405_0607, 64'h8877_6655_4433_2211,
                       96'h0123_4567_89AB_CDEF_FEDC_BA98);
    tick(); src_val = 1'b0;
    remaining = 4;
    for (int k = 0; k < 40 && remaining > 0; k++) begin
      dst_rdy = (k % 4 == 0) || (k % 4 == 3);
      sample();
      check("bp_val", {63'd0, dst_val}, 64'd1);
      if (remaining > 1) check("bp_src_rdy", {63'd0, src_rdy}, 64'd0);
      else               check("bp_last_src_rdy", {63'd0, src_rdy}, {63'd0, dst_rdy});
      if (dst_rdy) remaining--;
      tick();
    end
    dst_rdy = 1'b1;
    check("bp_delivered", 64'(remaining), 64'd0);
    sample();
    check("bp_done_val", {63'd0, dst_val}, 64'd0);
    check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // Back-to-back: eight beats with no idle cycle
    push_msg(64'hA5A5_A005_A5A5_A5A5, 64'h5A5A_5A5A_5A5A_5A5A, 96'hDEAD_BEEF_CAFE_F00D_1234_5678);
    push_msg(64'hFFFF_F00F_FFFF_FFFF, 64'h0, {96{1'b1}});
    tick(); src_val = 1'b1;
    src_data = mk_flit(64'hA5A5_A005_A5A5_A5A5, 64'h5A5A_5A5A_5A5A_5A5A,
                       96'hDEAD_BEEF_CAFE_F00D_1234_5678);
    tick();
    src_data = mk_flit(64'hFFFF_F00F_FFFF_FFFF, 64'h0, {96{1'b1}});
    for (int i = 0; i < 8; i++) begin
      sample();
      check("b2b_val", {63'd0, dst_val}, 64'd1);
      if (i == 3) begin
        check("b2b_chain_src_rdy", {63'd0, src_rdy}, 64'd1);
        tick(); src_val = 1'b0;
      end
      if (i == 4) check("b2b_second_hdr1", {62'd0, state}, 64'd1);
    end
    sample();
    check("b2b_done_val", {63'd0, dst_val}, 64'd0);
    check("b2b_queue_empty", 64'(exp_q.size()), 64'd0);

    // Stall on last beat with next flit waiting
    push_msg(64'h1234_5006_789A_BCDE, 64'h0F1E_2D3C_4B5A_6978, 96'h1111_2222_3333_4444_5555_6666);
    push_msg(64'h0000_0000_0000_0001, 64'hFEDC_BA98_7654_3210, 96'h7777_8888_9999_0000_AAAA_BBBB);
    tick(); src_val = 1'b1;
    src_data = mk_flit(64'h1234_5006_789A_BCDE, 64'h0F1E_2D3C_4B5A_6978,
                       96'h1111_2222_3333_4444_5555_6666);
    tick();
    src_data = mk_flit(64'h0000_0000_0000_0001, 64'hFEDC_BA98_7654_3210,
                       96'h7777_8888_9999_0000_AAAA_BBBB);
    repeat (3) sample();
    tick(); dst_rdy = 1'b0;
    sample();
    check("stl_last_src_rdy0", {63'd0, src_rdy}, 64'd0);
    tick();
    sample();
    check("stl_no_capture", {62'd0, state}, 64'd3);
    check("stl_src_rdy0_again", {63'd0, src_rdy}, 64'd0);
    tick(); dst_rdy = 1'b1;
    sample();
    check("stl_src_rdy_rise", {63'd0, src_rdy}, 64'd1);
    tick(); src_val = 1'b0;
    sample();
    check("stl_next_hdr1", {62'd0, state}, 64'd1);
    wait_idle("stl_idle");
    check("stl_queue_empty", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset mid-message, after Hdr2 was accepted
    push_msg(64'h7777_7007_7777_7777, 64'h6666_6666_6666_6666, 96'h0102_0304_0506_0708_090A_0B0C);
    tick(); src_val = 1'b1;
    src_data = mk_flit(64'h7777_7007_7777_7777, 64'h6666_6666_6666_6666,
                       96'h0102_0304_0506_0708_090A_0B0C);
    tick(); src_val = 1'b0;
    sample();
    sample();
    sample();
    check("ar_pre_state", {62'd0, state}, 64'd3);
    #2 rst_n = 1'b0;
    #1;
    check("ar_val_drop", {63'd0, dst_val}, 64'd0);
    check("ar_src_rdy", {63'd0, src_rdy}, 64'd0);
    check("ar_state", {62'd0, state}, 64'd0);
    exp_q.delete();
    tick(); rst_n = 1'b1;
    sample();
    check("ar_after_val", {63'd0, dst_val}, 64'd0);
    check("ar_after_src_rdy", {63'd0, src_rdy}, 64'd1);
    push_msg(64'h0F0F_0000_F0F0_0F0F, 64'h1357_9BDF_2468_ACE0, 96'hFACE_B00C_0000_1111_2222_3333);
    tick(); src_val = 1'b1;
    src_data = mk_flit(64'h0F0F_0000_F0F0_0F0F, 64'h1357_9BDF_2468_ACE0,
                       96'hFACE_B00C_0000_1111_2222_3333);
    tick(); src_val = 1'b0;
    sample();
    check("ar_restart_hdr1", {62'd0, state}, 64'd1);
    wait_idle("ar_idle");
    check("ar_queue_empty", 64'(exp_q.size()), 64'd0);

    // EXTRA_W=64: three flits, msg_len=2, extra unpadded
    tick(); src_val_b = 1'b1;
    src_data_b = {64'h3333_3003_3333_3333, 64'h4444_4444_4444_4444,
                  64'h0123_4567_89AB_CDEF, {320{1'b1}}};
    tick(); src_val_b = 1'b0;
    sample();
    check("e64_val", {63'd0, dst_val_b}, 64'd1);
    check("e64_hdr1", dst_data_b, 64'h3333_3023_3333_3333);
    check("e64_hdr1_src_rdy", {63'd0, src_rdy_b}, 64'd0);
    sample();
    check("e64_hdr2", dst_data_b, 64'h4444_4444_4444_4444);
    sample();
    check("e64_extra", dst_data_b, 64'h0123_4567_89AB_CDEF);
    check("e64_state_rem", {62'd0, state_b}, 64'd3);
    check("e64_last_src_rdy", {63'd0, src_rdy_b}, 64'd1);
    sample();
    check("e64_done_val", {63'd0, dst_val_b}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
